// File: rtl/param_lpf.sv
// Horizontal [1 2 1]/4 low-pass filter fed from a packed 2-pixel frame buffer.
// Optional test-pattern source enabled by defining LPF_TESTPAT_EN (adds input test_sel).
module param_lpf #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned LOG_W = 10,
  parameter int unsigned LOG_H = 9,
  parameter int unsigned C0_W  = 8,
  parameter int unsigned C1_W  = 5,
  parameter int unsigned C2_W  = 5,
  localparam int unsigned PIX_W = C0_W + C1_W + C2_W,
  localparam int unsigned MEM_W = 2 * PIX_W
) (
  input  logic             clock,
  input  logic             reset,
`ifdef LPF_TESTPAT_EN
  input  logic             test_sel,
`endif
  input  logic             frame_flag,
  input  logic             smooth,
  input  logic             done_lpf,
  output logic             lpf_flag,
  output logic             lpf_wr,
  output logic [LOG_W-1:0] lpf_x,
  output logic [LOG_H-1:0] lpf_y,
  output logic [MEM_W-1:0] lpf_pixel_write,
  input  logic [MEM_W-1:0] lpf_pixel_read,
  input  logic             request,
  output logic [PIX_W-1:0] pixel,
  output logic [LOG_W-1:0] x_out,
  output logic [LOG_H-1:0] y_out,
  output logic             pixel_flag
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CHECK = 3'd1;
  localparam logic [2:0] FETCH = 3'd2;
  localparam logic [2:0] CALC  = 3'd3;
  localparam logic [2:0] OUT   = 3'd4;

  localparam int unsigned SW = PIX_W + 2;
  localparam logic [LOG_W-1:0] X_LAST = LOG_W'(IMG_W - 1);
  localparam logic [LOG_H-1:0] Y_LAST = LOG_H'(IMG_H - 1);

  logic [2:0]       state;
  logic [LOG_W-1:0] ox;
  logic [LOG_H-1:0] oy;
  logic [MEM_W-1:0] prev_word, cur_word;
  logic [LOG_W-2:0] cur_idx;
  logic [LOG_H-1:0] cur_y;
  logic             cur_valid;
  logic             smooth_q, tsel_q;
  logic             lpf_flag_q;
  logic [LOG_W-1:0] lpf_x_q;
  logic [LOG_H-1:0] lpf_y_q;
  logic [PIX_W-1:0] pixel_q;
  logic [LOG_W-1:0] x_q;
  logic [LOG_H-1:0] y_q;
  logic             pflag_q;
  logic             test_en;

`ifdef LPF_TESTPAT_EN
  assign test_en = test_sel;
`else
  assign test_en = 1'b0;
`endif

  // Window lookup: a pixel comes from cur_word if its word index matches, else prev_word.
  function automatic logic [PIX_W-1:0] win_pix(input logic [LOG_W-1:0] i,
                                               input logic [LOG_W-2:0] idx,
                                               input logic [MEM_W-1:0] cw,
                                               input logic [MEM_W-1:0] pw);
    logic [MEM_W-1:0] w;
    w = (i[LOG_W-1:1] == idx) ? cw : pw;
    return i[0] ? w[PIX_W-1:0] : w[MEM_W-1:PIX_W];
  endfunction

  function automatic logic [SW-1:0] tap(input logic [SW-1:0] l, input logic [SW-1:0] c,
                                        input logic [SW-1:0] r);
    return (l + (c << 1) + r + SW'(2)) >> 2;
  endfunction

  logic [LOG_W-1:0] n;
  logic [LOG_W-2:0] n_idx;
  logic             buffered;
  logic [PIX_W-1:0] l_pix, c_pix, r_pix, filt, pattern, pixel_d;
  logic [SW-1:0]    f0, f1, f2;

  always_comb begin
    n        = (ox == X_LAST) ? ox : ox + 1'b1;
    n_idx    = n[LOG_W-1:1];
    buffered = cur_valid && (cur_y == oy) && (cur_idx == n_idx);

    c_pix = win_pix(ox, cur_idx, cur_word, prev_word);
    l_pix = (ox == '0) ? c_pix : win_pix(ox - 1'b1, cur_idx, cur_word, prev_word);
    r_pix = (ox == X_LAST) ? c_pix : win_pix(ox + 1'b1, cur_idx, cur_word, prev_word);

    f0 = tap(SW'(l_pix[PIX_W-1 -: C0_W]), SW'(c_pix[PIX_W-1 -: C0_W]),
             SW'(r_pix[PIX_W-1 -: C0_W]));
    f1 = tap(SW'(l_pix[C1_W+C2_W-1 -: C1_W]), SW'(c_pix[C1_W+C2_W-1 -: C1_W]),
             SW'(r_pix[C1_W+C2_W-1 -: C1_W]));
    f2 = tap(SW'(l_pix[C2_W-1:0]), SW'(c_pix[C2_W-1:0]), SW'(r_pix[C2_W-1:0]));
    filt = {f0[C0_W-1:0], f1[C1_W-1:0], f2[C2_W-1:0]};

    pattern = {{C0_W{ox[3] & oy[3]}}, C1_W'(1) << (C1_W - 1), C2_W'(1) << (C2_W - 1)};

    if (tsel_q)        pixel_d = pattern;
    else if (smooth_q) pixel_d = filt;
    else               pixel_d = c_pix;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      ox         <= '0;
      oy         <= '0;
      prev_word  <= '0;
      cur_word   <= '0;
      cur_idx    <= '0;
      cur_y      <= '0;
      cur_valid  <= 1'b0;
      smooth_q   <= 1'b0;
      tsel_q     <= 1'b0;
      lpf_flag_q <= 1'b0;
      lpf_x_q    <= '0;
      lpf_y_q    <= '0;
      pixel_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      pflag_q    <= 1'b0;
    end else if (frame_flag) begin
      state      <= IDLE;
      ox         <= '0;
      oy         <= '0;
      cur_valid  <= 1'b0;
      lpf_flag_q <= 1'b0;
      pflag_q    <= 1'b0;
    end else begin
      pflag_q <= 1'b0;
      case (state)
        IDLE: begin
          if (request) begin
            smooth_q <= smooth;
            tsel_q   <= test_en;
            state    <= CHECK;
            // Raise the read request straight away so it is visible the cycle after request.
            if (!test_en && !buffered) begin
              lpf_flag_q <= 1'b1;
              lpf_x_q    <= {n_idx, 1'b0};
              lpf_y_q    <= oy;
            end
          end
        end
        CHECK: state <= lpf_flag_q ? FETCH : CALC;
        FETCH: begin
          if (done_lpf) begin
            lpf_flag_q <= 1'b0;
            prev_word  <= (ox == '0) ? '0 : cur_word;
            cur_word   <= lpf_pixel_read;
            cur_idx    <= n_idx;
            cur_y      <= oy;
            cur_valid  <= 1'b1;
            state      <= CALC;
          end
        end
        CALC: begin
          pixel_q <= pixel_d;
          x_q     <= ox;
          y_q     <= oy;
          pflag_q <= 1'b1;
          state   <= OUT;
        end
        OUT: begin
          if (ox == X_LAST) begin
            ox <= '0;
            oy <= (oy == Y_LAST) ? '0 : oy + 1'b1;
          end else begin
            ox <= ox + 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign lpf_flag        = lpf_flag_q;
  assign lpf_wr          = 1'b0;
  assign lpf_x           = lpf_x_q;
  assign lpf_y           = lpf_y_q;
  assign lpf_pixel_write = '0;
  assign pixel           = pixel_q;
  assign x_out           = x_q;
  assign y_out           = y_q;
  assign pixel_flag      = pflag_q & ~frame_flag;

endmodule

// File: tb/tb_param_lpf.sv
// Scoreboard bench for param_lpf: random frame contents, random smoothing, random memory latency.
module tb_param_lpf;
  localparam int W = 16;
  localparam int H = 3;
  localparam int LW = 4;
  localparam int LH = 4;

  logic clock = 1'b0;
  logic reset, frame_flag, smooth, done_lpf, request, test_sel;
  logic [35:0] lpf_pixel_read;
  logic lpf_flag, lpf_wr, pixel_flag;
  logic [LW-1:0] lpf_x, x_out;
  logic [LH-1:0] lpf_y, y_out;
  logic [35:0] lpf_pixel_write;
  logic [17:0] pixel;

  param_lpf #(.IMG_W(W), .IMG_H(H), .LOG_W(LW), .LOG_H(LH), .C0_W(8), .C1_W(5), .C2_W(5)) dut (
    .clock(clock), .reset(reset),
`ifdef LPF_TESTPAT_EN
    .test_sel(test_sel),
`endif
    .frame_flag(frame_flag), .smooth(smooth), .done_lpf(done_lpf), .lpf_flag(lpf_flag),
    .lpf_wr(lpf_wr), .lpf_x(lpf_x), .lpf_y(lpf_y), .lpf_pixel_write(lpf_pixel_write),
    .lpf_pixel_read(lpf_pixel_read), .request(request), .pixel(pixel), .x_out(x_out),
    .y_out(y_out), .pixel_flag(pixel_flag)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [17:0] pix;
    int x;
    int y;
    bit fetch;
    int req_cyc;
  } exp_t;

  exp_t sbq[$];
  logic [17:0] mem [0:H-1][0:W-1];
  int cyc = 0;
  int tests = 0;
  int errors = 0;
  int n_out = 0;
  int done_cyc = 0;
  int exp_fx = 0, exp_fy = 0;
  bit mem_auto = 1'b1;
  logic [17:0] last_pix;
  // Reference-model position and which word was last fetched.
  int mx = 0, my = 0, bidx = 0, by = 0;
  bit bvalid = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int chan(input logic [17:0] p, input int lo, input int w);
    return int'((p >> lo) & ((18'd1 << w) - 1));
  endfunction

  function automatic logic [17:0] ref_pixel(input int x, input int y, input bit sm, input bit ts);
    logic [17:0] l, c, r, res;
    int los[3] = '{10, 5, 0};
    int ws[3] = '{8, 5, 5};
    if (ts) return {((x % 16) >= 8 && (y % 16) >= 8) ? 8'hFF : 8'h00, 5'b10000, 5'b10000};
    c = mem[y][x];
    l = (x == 0) ? c : mem[y][x-1];
    r = (x == W - 1) ? c : mem[y][x+1];
    if (!sm) return c;
    res = '0;
    for (int k = 0; k < 3; k++)
      res = res | 18'((chan(l, los[k], ws[k]) + 2 * chan(c, los[k], ws[k])
                       + chan(r, los[k], ws[k]) + 2) / 4) << los[k];
    return res;
  endfunction

  task automatic wait_out(input int target);
    for (int k = 0; k < 40 && n_out < target; k++) @(negedge clock);
    if (n_out < target) begin
      tests++;
      errors++;
      $display("FAIL out_timeout: got %0d pixels expected %0d", n_out, target);
      sbq.delete();
      n_out = target;
    end
  endtask

  task automatic issue(input bit sm, input bit ts, input bit spam);
    exp_t e;
    int nx, target;
    nx = (mx == W - 1) ? mx : mx + 1;
    e.fetch = !ts && !(bvalid && by == my && bidx == nx / 2);
    if (e.fetch) begin
      exp_fx = (nx / 2) * 2;
      exp_fy = my;
      bvalid = 1'b1;
      bidx = nx / 2;
      by = my;
    end
    e.pix = ref_pixel(mx, my, sm, ts);
    e.x = mx;
    e.y = my;
    target = n_out + 1;
    @(negedge clock);
    request = 1'b1;
    smooth = sm;
    test_sel = ts;
    e.req_cyc = cyc;
    sbq.push_back(e);
    @(negedge clock);
    request = spam;
    @(negedge clock);
    request = 1'b0;
    if (mx == W - 1) begin
      mx = 0;
      my = (my == H - 1) ? 0 : my + 1;
    end else mx++;
    wait_out(target);
    repeat ($urandom_range(0, 2)) @(negedge clock);
  endtask

  // Memory responder: returns the addressed word after a random delay.
  initial begin
    forever begin
      @(negedge clock);
      if (mem_auto && lpf_flag) begin
        chk("fetch_x", 64'(lpf_x), 64'(exp_fx));
        chk("fetch_y", 64'(lpf_y), 64'(exp_fy));
        repeat ($urandom_range(1, 3)) @(negedge clock);
        lpf_pixel_read = {mem[int'(lpf_y)][int'(lpf_x)], mem[int'(lpf_y)][int'(lpf_x) + 1]};
        done_lpf = 1'b1;
        done_cyc = cyc;
        @(negedge clock);
        done_lpf = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT strobes a pixel.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (pixel_flag) begin
        if (sbq.size() == 0) begin
          chk("unexpected_pixel_flag", 64'(pixel_flag), 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("pixel", 64'(pixel), 64'(e.pix));
          chk("x_out", 64'(x_out), 64'(e.x));
          chk("y_out", 64'(y_out), 64'(e.y));
          if (e.fetch) chk("latency_fetch", 64'(cyc - done_cyc), 64'd2);
          else chk("latency_buf", 64'(cyc - e.req_cyc), 64'd3);
        end
        last_pix = pixel;
        n_out++;
      end
    end
  end

  initial begin
    int base;
    reset = 1'b1;
    frame_flag = 1'b0;
    smooth = 1'b0;
    done_lpf = 1'b0;
    request = 1'b0;
    test_sel = 1'b0;
    lpf_pixel_read = '0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) mem[y][x] = 18'($urandom);
    mem[0][0][17:10] = 8'd100;
    mem[0][1][17:10] = 8'd200;
    mem[0][2][17:10] = 8'd40;
    repeat (3) @(negedge clock);
    chk("rst_pixel_flag", 64'(pixel_flag), 64'd0);
    chk("rst_lpf_flag", 64'(lpf_flag), 64'd0);
    chk("rst_pixel", 64'(pixel), 64'd0);
    chk("rst_xy", 64'({x_out, y_out}), 64'd0);
    chk("lpf_wr", 64'({lpf_wr, lpf_pixel_write}), 64'd0);
    reset = 1'b0;

    issue(1'b1, 1'b0, 1'b0);
    chk("c0_first", 64'(last_pix[17:10]), 64'd125);
    issue(1'b1, 1'b0, 1'b0);
    chk("c0_second", 64'(last_pix[17:10]), 64'd135);
    for (int i = 2; i < W * H; i++) issue(1'($urandom), 1'b0, 1'($urandom));
    chk("frame_last_xy", 64'({x_out, y_out}), 64'({4'(W - 1), 4'(H - 1)}));
    for (int i = 0; i < 5; i++) issue(1'($urandom), 1'b0, 1'b0);

    // Abort an outstanding fetch at x=5 with frame_flag.
    mem_auto = 1'b0;
    base = n_out;
    @(negedge clock);
    request = 1'b1;
    @(negedge clock);
    request = 1'b0;
    for (int k = 0; k < 5 && !lpf_flag; k++) @(negedge clock);
    chk("abort_lpf_flag_up", 64'(lpf_flag), 64'd1);
    frame_flag = 1'b1;
    @(negedge clock);
    frame_flag = 1'b0;
    chk("abort_lpf_flag_down", 64'(lpf_flag), 64'd0);
    repeat (6) @(negedge clock);
    chk("abort_no_pixel", 64'(n_out), 64'(base));
    mx = 0;
    my = 0;
    bvalid = 1'b0;
    mem_auto = 1'b1;

    mem[0][0] = 18'h3FFFF;
    mem[0][1] = 18'h0;
    issue(1'b0, 1'b0, 1'b0);
    chk("bypass_max", 64'(last_pix), 64'h3FFFF);
    for (int i = 0; i < 20; i++) issue(1'($urandom), 1'b0, 1'($urandom));
`ifdef LPF_TESTPAT_EN
    for (int i = 0; i < 4; i++) issue(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) issue(1'b1, 1'b0, 1'b0);
`endif
    repeat (4) @(negedge clock);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
